// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding, field limits and wrap helpers for the clock mode controller
// Purpose: common types and constants imported by clock_mode_controller.
// Contents: state_t encoding, hour/minute widths and maxima, wrap-around increment helpers.
package clock_pkg;

   localparam int HOUR_W = 4;
   localparam int MIN_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd11;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10
   } state_t;

   function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
      return (h == HOUR_MAX) ? '0 : h + 4'd1;
   endfunction

   function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
      return (m == MIN_MAX) ? '0 : m + 6'd1;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
// Purpose: bring an asynchronous debounced button level into the clock domain and
//          emit one single-cycle pulse per rising edge (a held button gives one pulse).
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   btn   - debounced button level, asynchronous to clock
//   pulse - one-cycle event, asserted three cycles after the pin edge
module btn_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_d <= sync;
         pulse  <= sync & ~sync_d;
      end
   end

endmodule

// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - one-second tick generator and button-driven set-time FSM
// Purpose: generates the seconds count enable, runs RUN -> SET_HOUR -> SET_MIN -> RUN,
//          and issues a single load strobe with the edited hour/minute.
// Ports:
//   clock, reset        - system clock / asynchronous active-low reset
//   btn_mode, btn_inc   - debounced button levels, asynchronous
//   cur_hour, cur_min   - current time from the counter chain
//   tick_enable         - one-cycle seconds count enable (RUN only, never with load)
//   load                - one-cycle strobe carrying load_hour/load_min
//   load_hour, load_min - last committed values
//   set_mode            - current state (00 RUN, 01 SET_HOUR, 10 SET_MIN)
//   blink               - blink phase of the edited field, 0 in RUN
module clock_mode_controller
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int TIMEOUT_S = 10,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              btn_mode,
   input  logic              btn_inc,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output logic              tick_enable,
   output logic              load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MIN_W-1:0]  load_min,
   output logic [1:0]        set_mode,
   output logic              blink
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT_S + 1);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_S - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

   logic mode_ev;
   logic inc_ev;

   btn_sync_edge u_mode_sync (
      .clock (clock),
      .reset (reset),
      .btn   (btn_mode),
      .pulse (mode_ev)
   );

   btn_sync_edge u_inc_sync (
      .clock (clock),
      .reset (reset),
      .btn   (btn_inc),
      .pulse (inc_ev)
   );

   // Prescaler free-runs in every state; load does not restart it.
   logic [PW-1:0] pre_cnt;
   logic          sec_pulse;

   assign sec_pulse = (pre_cnt == PRE_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= sec_pulse ? '0 : pre_cnt + 1'b1;
      end
   end

   state_t            state, state_nx;
   logic [HOUR_W-1:0] shadow_hour, shadow_hour_nx;
   logic [MIN_W-1:0]  shadow_min, shadow_min_nx;
   logic [TW-1:0]     to_cnt, to_cnt_nx;
   logic              commit;

   // Priority within a set state: mode_ev, then inc_ev, then timeout.
   always_comb begin
      state_nx       = state;
      shadow_hour_nx = shadow_hour;
      shadow_min_nx  = shadow_min;
      to_cnt_nx      = to_cnt;
      commit         = 1'b0;
      case (state)
         ST_RUN: begin
            if (mode_ev) begin
               shadow_hour_nx = cur_hour;
               shadow_min_nx  = cur_min;
               to_cnt_nx      = '0;
               state_nx       = ST_SET_HOUR;
            end
         end
         ST_SET_HOUR: begin
            if (mode_ev) begin
               to_cnt_nx = '0;
               state_nx  = ST_SET_MIN;
            end else if (inc_ev) begin
               shadow_hour_nx = next_hour(shadow_hour);
               to_cnt_nx      = '0;
            end else if (sec_pulse) begin
               if (to_cnt == TO_LAST) begin
                  to_cnt_nx = '0;
                  state_nx  = ST_RUN;
               end else begin
                  to_cnt_nx = to_cnt + 1'b1;
               end
            end
         end
         ST_SET_MIN: begin
            if (mode_ev) begin
               commit   = 1'b1;
               state_nx = ST_RUN;
            end else if (inc_ev) begin
               shadow_min_nx = next_min(shadow_min);
               to_cnt_nx     = '0;
            end else if (sec_pulse) begin
               if (to_cnt == TO_LAST) begin
                  to_cnt_nx = '0;
                  state_nx  = ST_RUN;
               end else begin
                  to_cnt_nx = to_cnt + 1'b1;
               end
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         shadow_hour <= '0;
         shadow_min  <= '0;
         to_cnt      <= '0;
         load        <= 1'b0;
         load_hour   <= '0;
         load_min    <= '0;
      end else begin
         state       <= state_nx;
         shadow_hour <= shadow_hour_nx;
         shadow_min  <= shadow_min_nx;
         to_cnt      <= to_cnt_nx;
         load        <= commit;
         if (commit) begin
            load_hour <= shadow_hour;
            load_min  <= shadow_min;
         end
      end
   end

   // Blink restarts visibly-on whenever the edited field changes.
   logic [BW-1:0] blk_cnt;
   logic          phase;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blk_cnt <= '0;
         phase   <= 1'b0;
      end else if (state_nx != state) begin
         blk_cnt <= '0;
         phase   <= 1'b1;
      end else if (blk_cnt == BLK_LAST) begin
         blk_cnt <= '0;
         phase   <= ~phase;
      end else begin
         blk_cnt <= blk_cnt + 1'b1;
      end
   end

   assign set_mode    = state;
   assign tick_enable = sec_pulse && (state == ST_RUN) && !load;
   assign blink       = phase && (state != ST_RUN);

endmodule
